eth_ipv4_cfg_regs: RTL
======================

ETH_IPV4_CFG_REGS -- requirements
Module: eth_ipv4_cfg_regs

Interface
REQ-001 SHALL have parameter REG_AWIDTH, default 14, register address width.
REQ-002 SHALL have parameter BASE, default 0, base byte address of the register window.
REQ-003 SHALL have parameter NUM_UDP, default 2, range 1-8, number of CHDR UDP ports.
REQ-004 SHALL have parameter NUM_DROP_CH, default 2, range 1-16, number of drop-counter channels.
REQ-005 SHALL have parameter CNT_W, default 32, range 8-32, drop-counter width.
REQ-006 SHALL have parameter PAUSE_EN, default 0; when 0, pause writes are ignored and pause reads return 0.
REQ-007 SHALL have port bus_clk, input, 1, sole clock; one clock, synchronous active-high reset.
REQ-008 SHALL have port bus_rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have ports reg_wr_req (in, 1), reg_wr_addr (in, REG_AWIDTH) and reg_wr_data (in, 32), forming the write port.
REQ-010 SHALL have ports reg_rd_req (in, 1), reg_rd_addr (in, REG_AWIDTH), reg_rd_resp (out, 1) and reg_rd_data (out, 32), forming the read port.
REQ-011 SHALL have port drop_event, input, NUM_DROP_CH, one-cycle pulse per dropped packet; the pulse is already in bus_clk.
REQ-012 SHALL have ports my_mac (out, 48), my_ip (out, 32) and my_udp_port (out, 16*NUM_UDP); port i occupies bits [16i+15:16i]; all are active configuration.
REQ-013 SHALL have ports my_pause_set (out, 16) and my_pause_clear (out, 16), the pause thresholds.
REQ-014 SHALL have port cfg_update, output, 1, one-cycle pulse when the active configuration changes.

Function
REQ-015 Address map SHALL use byte offsets from BASE with a 4-byte stride:
- 0x00 MAC_LSB
- 0x04 MAC_MSB (bits 15:0)
- 0x08 IP
- 0x0C COMMIT
- 0x10 PAUSE {clear[31:16], set[15:0]}
- 0x14 STATUS
- 0x100+4i UDP[i]
- 0x200+4c DROP[c]
REQ-016 Writes to MAC_LSB, MAC_MSB, IP and UDP[i] SHALL update shadow registers only; active outputs SHALL NOT change.
REQ-017 A write to COMMIT with data[0]=1 SHALL copy all shadow registers to the active registers on the next edge and pulse cfg_update one cycle later.
- Net latency: outputs valid in cycle N+1, cfg_update high in cycle N+1.
- COMMIT data[0]=0 SHALL have no effect.
REQ-018 Reads of MAC, IP and UDP addresses SHALL return shadow values.
REQ-019 STATUS SHALL read:
- bit0 = shadow != active (pending)
- bit1 = sticky pause-reject flag, cleared on read of STATUS
- bits[7:4] = NUM_UDP
- bits[15:8] = NUM_DROP_CH
REQ-020 A PAUSE write with set <= clear SHALL be rejected: thresholds unchanged, pause-reject flag set.
REQ-021 A valid PAUSE write SHALL update the thresholds directly (no commit) and pulse cfg_update.
REQ-022 reg_rd_resp SHALL assert exactly one cycle after reg_rd_req for a mapped address, with reg_rd_data valid in that same cycle.
REQ-023 Reads of unmapped addresses, including UDP indices >= NUM_UDP and DROP indices >= NUM_DROP_CH, SHALL produce no reg_rd_resp; writes to them SHALL be ignored.
REQ-024 reg_rd_resp SHALL deassert after one cycle; back-to-back reads SHALL each respond.
REQ-025 Each DROP[c] counter SHALL increment by 1 per drop_event[c] pulse and saturate at 2^CNT_W-1; the read value is zero-extended to 32 bits.
REQ-026 Reading DROP[c] SHALL return the pre-read value and clear the counter.
- Simultaneous drop_event[c] during the read SHALL leave the counter at 1; no event is lost.
REQ-027 A simultaneous read and write SHALL both take effect; the read returns the pre-write value.
REQ-028 A COMMIT write in the same cycle as a shadow write SHALL commit the pre-write shadow value.

Reset
REQ-029 On bus_rst, active and shadow registers SHALL reset to the following, and cfg_update SHALL NOT pulse on reset:
- MAC 00:80:2f:16:c5:2f
- IP 192.168.10.2
- UDP[i] 49153+i
- pause set 40, clear 20
REQ-030 On bus_rst, reg_rd_resp, reg_rd_data, cfg_update, all counters and the reject flag SHALL be 0.
REQ-031 Reset asserted mid-transaction SHALL abort any pending response; there is no response in the cycle after reset deasserts.

Structure
REQ-032 Register offsets, default MAC/IP/UDP/pause constants and the STATUS bit positions SHALL reside in the shared eth_regs package.
REQ-033 The drop counter SHALL be a sub-module, eth_drop_counter (CNT_W-wide, saturating, clear-on-read with event merge), instantiated NUM_DROP_CH times.

Verification
REQ-034 Reset: assert bus_rst, then read MAC_LSB -> 0x2f16c52f, resp one cycle later; UDP[1] -> 49154; my_mac = 00802f16c52f.
REQ-035 Shadow/commit: write IP 0xC0A80A05 -> my_ip unchanged, STATUS bit0 = 1; write COMMIT 1 -> my_ip = 0xC0A80A05 next cycle, cfg_update pulses once, STATUS bit0 = 0.
REQ-036 Counters:
- 5 pulses on drop_event[1], read DROP[1] -> 5, read again -> 0.
- Pulse on the same cycle as a read -> next read returns 1.
REQ-037 Saturation: CNT_W=8, 300 pulses -> read 255.
REQ-038 Pause: write PAUSE {clear=50, set=30} -> rejected, STATUS bit1 = 1, then reads 0 on the second STATUS read; write {20, 60} -> my_pause_set=60, my_pause_clear=20.
REQ-039 Unmapped access: read UDP[NUM_UDP] -> no resp; write to it -> no state change.

Source files
------------

// File: rtl/eth_regs_pkg.sv
// Shared register-map definitions for the Ethernet IPv4 configuration block.
// Holds the byte offsets of every register, the reset-default MAC/IP/UDP/pause
// values, the STATUS bit positions and the decoded-access types used by the
// register file.
package eth_regs;

    // Decoded target of a register access.
    typedef enum logic [3:0] {
        SelNone,
        SelMacLsb,
        SelMacMsb,
        SelIp,
        SelCommit,
        SelPause,
        SelStatus,
        SelUdp,
        SelDrop
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [3:0] idx;  // UDP port or drop channel index
    } reg_dec_t;

    // Byte offsets relative to the register window base.
    localparam logic [31:0] OffMacLsb   = 32'h000;
    localparam logic [31:0] OffMacMsb   = 32'h004;
    localparam logic [31:0] OffIp       = 32'h008;
    localparam logic [31:0] OffCommit   = 32'h00c;
    localparam logic [31:0] OffPause    = 32'h010;
    localparam logic [31:0] OffStatus   = 32'h014;
    localparam logic [31:0] OffUdpBase  = 32'h100;
    localparam logic [31:0] OffDropBase = 32'h200;

    // Reset defaults: MAC 00:80:2f:16:c5:2f, IP 192.168.10.2, UDP 49153+i.
    localparam logic [47:0] DefaultMac        = 48'h0080_2f16_c52f;
    localparam logic [31:0] DefaultIp         = 32'hc0a8_0a02;
    localparam logic [15:0] DefaultUdpBase    = 16'd49153;
    localparam logic [15:0] DefaultPauseSet   = 16'd40;
    localparam logic [15:0] DefaultPauseClear = 16'd20;

    // STATUS register layout.
    localparam int unsigned StatPendingBit = 0;
    localparam int unsigned StatRejectBit  = 1;
    localparam int unsigned StatNumUdpLsb  = 4;
    localparam int unsigned StatNumDropLsb = 8;

endpackage

// File: rtl/eth_drop_counter.sv
// Saturating drop-event counter with clear-on-read.
// Ports:
//   clk_i        - clock
//   rst_i        - synchronous active-high reset
//   drop_pulse_i - one-cycle pulse per dropped packet
//   clear_i      - counter is being read this cycle; clear it
//   count_o      - current count (value returned by a read this cycle)
module eth_drop_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             drop_pulse_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            // An event coinciding with the read is kept, not lost.
            count_d = {{(CNT_W-1){1'b0}}, drop_pulse_i};
        end else if (drop_pulse_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/eth_ipv4_cfg_regs.sv
// Ethernet IPv4 configuration register file.
// Shadow/active MAC, IP and UDP ports (software writes shadows, COMMIT copies
// them to the active outputs), directly-written pause thresholds, a STATUS
// register and per-channel clear-on-read drop counters.
// Ports:
//   bus_clk, bus_rst          - clock, synchronous active-high reset
//   reg_wr_req/addr/data      - write port (one write per cycle)
//   reg_rd_req/addr           - read request; reg_rd_resp/data one cycle later
//   drop_event                - per-channel drop pulses
//   my_mac, my_ip, my_udp_port- active configuration
//   my_pause_set/clear        - pause thresholds
//   cfg_update                - one-cycle pulse when active config changes
module eth_ipv4_cfg_regs
    import eth_regs::*;
#(
    parameter int unsigned REG_AWIDTH  = 14,
    parameter int unsigned BASE        = 0,
    parameter int unsigned NUM_UDP     = 2,
    parameter int unsigned NUM_DROP_CH = 2,
    parameter int unsigned CNT_W       = 32,
    parameter bit          PAUSE_EN    = 1'b0
) (
    input  logic                      bus_clk,
    input  logic                      bus_rst,
    input  logic                      reg_wr_req,
    input  logic [REG_AWIDTH-1:0]     reg_wr_addr,
    input  logic [31:0]               reg_wr_data,
    input  logic                      reg_rd_req,
    input  logic [REG_AWIDTH-1:0]     reg_rd_addr,
    output logic                      reg_rd_resp,
    output logic [31:0]               reg_rd_data,
    input  logic [NUM_DROP_CH-1:0]    drop_event,
    output logic [47:0]               my_mac,
    output logic [31:0]               my_ip,
    output logic [16*NUM_UDP-1:0]     my_udp_port,
    output logic [15:0]               my_pause_set,
    output logic [15:0]               my_pause_clear,
    output logic                      cfg_update
);

    function automatic logic [16*NUM_UDP-1:0] udp_defaults();
        logic [16*NUM_UDP-1:0] v;
        for (int i = 0; i < NUM_UDP; i++) begin
            v[16*i +: 16] = DefaultUdpBase + 16'(i);
        end
        return v;
    endfunction

    localparam logic [16*NUM_UDP-1:0] UdpResetVal = udp_defaults();

    // Map an absolute address onto a register; misaligned, below-base and
    // out-of-range indices decode to SelNone.
    function automatic reg_dec_t decode(input logic [REG_AWIDTH-1:0] addr);
        reg_dec_t    dec;
        logic [32:0] diff;
        logic [31:0] off;
        logic [31:0] rel;
        dec.sel = SelNone;
        dec.idx = '0;
        diff    = {1'b0, 32'(addr)} - 33'(BASE);
        off     = diff[31:0];
        rel     = '0;
        if (!diff[32] && (off[1:0] == 2'b00)) begin
            if (off == OffMacLsb) begin
                dec.sel = SelMacLsb;
            end else if (off == OffMacMsb) begin
                dec.sel = SelMacMsb;
            end else if (off == OffIp) begin
                dec.sel = SelIp;
            end else if (off == OffCommit) begin
                dec.sel = SelCommit;
            end else if (off == OffPause) begin
                dec.sel = SelPause;
            end else if (off == OffStatus) begin
                dec.sel = SelStatus;
            end else if ((off >= OffUdpBase) && (off < OffUdpBase + 4 * NUM_UDP)) begin
                rel     = off - OffUdpBase;
                dec.sel = SelUdp;
                dec.idx = rel[5:2];
            end else if ((off >= OffDropBase) && (off < OffDropBase + 4 * NUM_DROP_CH)) begin
                rel     = off - OffDropBase;
                dec.sel = SelDrop;
                dec.idx = rel[5:2];
            end
        end
        return dec;
    endfunction

    reg_dec_t wr_dec, rd_dec;
    assign wr_dec = decode(reg_wr_addr);
    assign rd_dec = decode(reg_rd_addr);

    logic [47:0]           shadow_mac_q, shadow_mac_d, active_mac_q, active_mac_d;
    logic [31:0]           shadow_ip_q, shadow_ip_d, active_ip_q, active_ip_d;
    logic [16*NUM_UDP-1:0] shadow_udp_q, shadow_udp_d, active_udp_q, active_udp_d;
    logic [15:0]           pause_set_q, pause_set_d, pause_clear_q, pause_clear_d;
    logic                  reject_q, reject_d;
    logic                  cfg_update_q, cfg_update_d;
    logic                  rd_resp_q, rd_resp_d;
    logic [31:0]           rd_data_q, rd_data_d;

    logic                  pending;
    logic [31:0]           status_word;
    logic [NUM_DROP_CH-1:0] rd_drop_clr;
    logic [CNT_W-1:0]      drop_cnt [NUM_DROP_CH];

    // Drop counters; a read of DROP[c] clears channel c.
    always_comb begin
        for (int c = 0; c < NUM_DROP_CH; c++) begin
            rd_drop_clr[c] = reg_rd_req && (rd_dec.sel == SelDrop) && (rd_dec.idx == 4'(c));
        end
    end

    for (genvar c = 0; c < NUM_DROP_CH; c++) begin : g_drop
        eth_drop_counter #(
            .CNT_W (CNT_W)
        ) u_drop_counter (
            .clk_i        (bus_clk),
            .rst_i        (bus_rst),
            .drop_pulse_i (drop_event[c]),
            .clear_i      (rd_drop_clr[c]),
            .count_o      (drop_cnt[c])
        );
    end

    assign pending = (shadow_mac_q != active_mac_q) || (shadow_ip_q != active_ip_q) ||
                     (shadow_udp_q != active_udp_q);

    always_comb begin
        status_word                          = '0;
        status_word[StatPendingBit]          = pending;
        status_word[StatRejectBit]           = reject_q;
        status_word[StatNumUdpLsb +: 4]      = 4'(NUM_UDP);
        status_word[StatNumDropLsb +: 8]     = 8'(NUM_DROP_CH);
    end

    // Read path: data is taken from pre-edge state, so a same-cycle write is
    // not visible to the read.
    always_comb begin
        rd_resp_d = reg_rd_req && (rd_dec.sel != SelNone);
        rd_data_d = '0;
        if (reg_rd_req) begin
            unique case (rd_dec.sel)
                SelMacLsb: rd_data_d = shadow_mac_q[31:0];
                SelMacMsb: rd_data_d = {16'h0000, shadow_mac_q[47:32]};
                SelIp:     rd_data_d = shadow_ip_q;
                SelPause: begin
                    if (PAUSE_EN) begin
                        rd_data_d = {pause_clear_q, pause_set_q};
                    end
                end
                SelStatus: rd_data_d = status_word;
                SelUdp: begin
                    for (int i = 0; i < NUM_UDP; i++) begin
                        if (rd_dec.idx == 4'(i)) begin
                            rd_data_d = {16'h0000, shadow_udp_q[16*i +: 16]};
                        end
                    end
                end
                SelDrop: begin
                    for (int c = 0; c < NUM_DROP_CH; c++) begin
                        if (rd_dec.idx == 4'(c)) begin
                            rd_data_d = 32'(drop_cnt[c]);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Write path and commit.
    always_comb begin
        shadow_mac_d  = shadow_mac_q;
        shadow_ip_d   = shadow_ip_q;
        shadow_udp_d  = shadow_udp_q;
        active_mac_d  = active_mac_q;
        active_ip_d   = active_ip_q;
        active_udp_d  = active_udp_q;
        pause_set_d   = pause_set_q;
        pause_clear_d = pause_clear_q;
        reject_d      = reject_q;
        cfg_update_d  = 1'b0;

        if (reg_rd_req && (rd_dec.sel == SelStatus)) begin
            reject_d = 1'b0;
        end

        if (reg_wr_req) begin
            unique case (wr_dec.sel)
                SelMacLsb: shadow_mac_d[31:0]  = reg_wr_data;
                SelMacMsb: shadow_mac_d[47:32] = reg_wr_data[15:0];
                SelIp:     shadow_ip_d         = reg_wr_data;
                SelUdp: begin
                    for (int i = 0; i < NUM_UDP; i++) begin
                        if (wr_dec.idx == 4'(i)) begin
                            shadow_udp_d[16*i +: 16] = reg_wr_data[15:0];
                        end
                    end
                end
                SelCommit: begin
                    // Copies the pre-edge shadows.
                    if (reg_wr_data[0]) begin
                        active_mac_d = shadow_mac_q;
                        active_ip_d  = shadow_ip_q;
                        active_udp_d = shadow_udp_q;
                        cfg_update_d = 1'b1;
                    end
                end
                SelPause: begin
                    if (PAUSE_EN) begin
                        // set must be strictly above clear to give hysteresis.
                        if (reg_wr_data[15:0] > reg_wr_data[31:16]) begin
                            pause_set_d   = reg_wr_data[15:0];
                            pause_clear_d = reg_wr_data[31:16];
                            cfg_update_d  = 1'b1;
                        end else begin
                            // Set after the read-clear so a same-cycle reject survives.
                            reject_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            shadow_mac_q  <= DefaultMac;
            shadow_ip_q   <= DefaultIp;
            shadow_udp_q  <= UdpResetVal;
            active_mac_q  <= DefaultMac;
            active_ip_q   <= DefaultIp;
            active_udp_q  <= UdpResetVal;
            pause_set_q   <= DefaultPauseSet;
            pause_clear_q <= DefaultPauseClear;
            reject_q      <= 1'b0;
            cfg_update_q  <= 1'b0;
            rd_resp_q     <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            shadow_mac_q  <= shadow_mac_d;
            shadow_ip_q   <= shadow_ip_d;
            shadow_udp_q  <= shadow_udp_d;
            active_mac_q  <= active_mac_d;
            active_ip_q   <= active_ip_d;
            active_udp_q  <= active_udp_d;
            pause_set_q   <= pause_set_d;
            pause_clear_q <= pause_clear_d;
            reject_q      <= reject_d;
            cfg_update_q  <= cfg_update_d;
            rd_resp_q     <= rd_resp_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign reg_rd_resp    = rd_resp_q;
    assign reg_rd_data    = rd_data_q;
    assign my_mac         = active_mac_q;
    assign my_ip          = active_ip_q;
    assign my_udp_port    = active_udp_q;
    assign my_pause_set   = pause_set_q;
    assign my_pause_clear = pause_clear_q;
    assign cfg_update     = cfg_update_q;

endmodule
